// File: rtl/d_split.sv
// ============================================================================
// Module   : d_split
// Purpose  : Dcache request splitter. Buffers LSQ ops and steers each one to the
//            even/odd bank pipe, splitting line-crossing LD/ST ops across both.
// Options  : D_SPLIT_ALIGN_CHECK_EN adds misaligned-access rejection outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_split #(
    parameter int OOO_TAG_SIZE = 10,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_data,
    input  logic [1:0]              req_size,
    input  logic [2:0]              req_op,
    input  logic                    req_sext,
    input  logic [OOO_TAG_SIZE-1:0] req_tag,
    output logic                    e_valid,
    input  logic                    e_ready,
    output logic [31:0]             e_addr,
    output logic [31:0]             e_data,
    output logic [1:0]              e_size,
    output logic [2:0]              e_op,
    output logic [OOO_TAG_SIZE-1:0] e_tag,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [31:0]             o_addr,
    output logic [31:0]             o_data,
    output logic [1:0]              o_size,
    output logic [2:0]              o_op,
    output logic [OOO_TAG_SIZE-1:0] o_tag,
    output logic                    meta_valid,
    output logic [1:0]              meta_size,
    output logic                    meta_sext,
    output logic                    meta_split,
    output logic [OOO_TAG_SIZE-1:0] meta_tag
`ifdef D_SPLIT_ALIGN_CHECK_EN
    ,
    output logic                    misalign_valid,
    output logic [OOO_TAG_SIZE-1:0] misalign_tag
`endif
);

    localparam int       PTR_W   = $clog2(FIFO_DEPTH);
    localparam int       CNT_W   = PTR_W + 1;
    localparam bit [2:0] OP_NOOP = 3'd0;
    localparam bit [2:0] OP_LD   = 3'd1;
    localparam bit [2:0] OP_ST   = 3'd2;

    typedef struct packed {
        logic [31:0]             addr;
        logic [31:0]             data;
        logic [1:0]              size;
        logic [2:0]              op;
        logic                    sext;
        logic [OOO_TAG_SIZE-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_O = 2'd2,
        S_WAIT_E = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    entry_t            mem_q [FIFO_DEPTH];

    logic              full, push, pop;
    entry_t            head;
    logic              is_ldst, split, misalign, primary_odd;
    logic              need_e, need_o, acc_e, acc_o;
    logic [4:0]        cross_sum;
    logic [2:0]        neg_lo;
    logic [5:0]        shamt;
    logic [31:0]       sec_addr, sec_data;
    logic              e_fire, o_fire, meta_fire, mis_fire;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign req_ready = ~full;
    assign push      = req_valid & req_ready;
    assign head      = mem_q[rd_ptr_q];

    // ---------------- head decode ----------------
    assign is_ldst     = (head.op == OP_LD) || (head.op == OP_ST);
    assign cross_sum   = {1'b0, head.addr[3:0]} + {3'b000, head.size};
    assign split       = is_ldst && (cross_sum >= 5'd16);
    assign primary_odd = head.addr[4];
    assign sec_addr    = {head.addr[31:4] + 28'd1, 4'b0000};
    // (16 - addr[3:0]) * 8 truncated to 6 bits only depends on -addr[2:0] mod 8
    assign neg_lo      = 3'd0 - head.addr[2:0];
    assign shamt       = {neg_lo, 3'b000};
    assign sec_data    = head.data >> shamt;
    assign need_e      = split | ~primary_odd;
    assign need_o      = split | primary_odd;
    assign acc_e       = need_e & e_ready;
    assign acc_o       = need_o & o_ready;

`ifdef D_SPLIT_ALIGN_CHECK_EN
    assign misalign = is_ldst &&
                      (((head.size == 2'd1) && head.addr[0]) ||
                       ((head.size == 2'd3) && (head.addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        e_fire    = 1'b0;
        o_fire    = 1'b0;
        meta_fire = 1'b0;
        mis_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (push) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if ((head.op == OP_NOOP) || misalign) begin
                    pop      = 1'b1;
                    mis_fire = misalign;
                end else begin
                    e_fire = need_e;
                    o_fire = need_o;
                    if ((~need_e | acc_e) && (~need_o | acc_o)) begin
                        pop       = 1'b1;
                        meta_fire = 1'b1;
                    end else if (split && acc_e) begin
                        state_d = S_WAIT_O;
                    end else if (split && acc_o) begin
                        state_d = S_WAIT_E;
                    end
                end
            end
            S_WAIT_O: begin
                o_fire = 1'b1;
                if (o_ready) begin
                    pop       = 1'b1;
                    meta_fire = 1'b1;
                end
            end
            S_WAIT_E: begin
                e_fire = 1'b1;
                if (e_ready) begin
                    pop       = 1'b1;
                    meta_fire = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) state_d = ((count_q > CNT_W'(1)) || push) ? S_ISSUE : S_IDLE;
    end

    // ---------------- input FIFO ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: req_addr, data: req_data, size: req_size,
                                       op: req_op, sext: req_sext, tag: req_tag};
    end

    // ---------------- outputs (zeroed when not valid) ----------------
    assign e_valid = e_fire;
    assign e_addr  = e_fire ? (primary_odd ? sec_addr : head.addr) : 32'd0;
    assign e_data  = e_fire ? (primary_odd ? sec_data : head.data) : 32'd0;
    assign e_size  = e_fire ? head.size : 2'd0;
    assign e_op    = e_fire ? head.op   : 3'd0;
    assign e_tag   = e_fire ? head.tag  : '0;

    assign o_valid = o_fire;
    assign o_addr  = o_fire ? (primary_odd ? head.addr : sec_addr) : 32'd0;
    assign o_data  = o_fire ? (primary_odd ? head.data : sec_data) : 32'd0;
    assign o_size  = o_fire ? head.size : 2'd0;
    assign o_op    = o_fire ? head.op   : 3'd0;
    assign o_tag   = o_fire ? head.tag  : '0;

    assign meta_valid = meta_fire;
    assign meta_size  = meta_fire ? head.size : 2'd0;
    assign meta_sext  = meta_fire & head.sext;
    assign meta_split = meta_fire & split;
    assign meta_tag   = meta_fire ? head.tag : '0;

`ifdef D_SPLIT_ALIGN_CHECK_EN
    assign misalign_valid = mis_fire;
    assign misalign_tag   = mis_fire ? head.tag : '0;
`else
    logic unused_mis;
    assign unused_mis = mis_fire;
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_split.sv
// ============================================================================
// Module   : tb_d_split
// Purpose  : Directed self-checking bench for d_split.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_split;

    localparam int TAG_W = 10;

    logic             clk, rst;
    logic             req_valid, req_ready, req_sext;
    logic [31:0]      req_addr, req_data;
    logic [1:0]       req_size;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             e_valid, e_ready, o_valid, o_ready;
    logic [31:0]      e_addr, e_data, o_addr, o_data;
    logic [1:0]       e_size, o_size;
    logic [2:0]       e_op, o_op;
    logic [TAG_W-1:0] e_tag, o_tag;
    logic             meta_valid, meta_sext, meta_split;
    logic [1:0]       meta_size;
    logic [TAG_W-1:0] meta_tag;
`ifdef D_SPLIT_ALIGN_CHECK_EN
    logic             misalign_valid;
    logic [TAG_W-1:0] misalign_tag;
`endif

    int n_checks = 0;
    int n_errors = 0;

    d_split #(.OOO_TAG_SIZE(TAG_W), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size), .req_op(req_op),
        .req_sext(req_sext), .req_tag(req_tag),
        .e_valid(e_valid), .e_ready(e_ready), .e_addr(e_addr), .e_data(e_data),
        .e_size(e_size), .e_op(e_op), .e_tag(e_tag),
        .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr), .o_data(o_data),
        .o_size(o_size), .o_op(o_op), .o_tag(o_tag),
        .meta_valid(meta_valid), .meta_size(meta_size), .meta_sext(meta_sext),
        .meta_split(meta_split), .meta_tag(meta_tag)
`ifdef D_SPLIT_ALIGN_CHECK_EN
        , .misalign_valid(misalign_valid), .misalign_tag(misalign_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs changed afterwards settle well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic [2:0] op, input logic [TAG_W-1:0] t);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_op    = op;
        req_sext  = 1'b0;
        req_tag   = t;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        req_op = '0; req_sext = 1'b0; req_tag = '0; e_ready = 1'b0; o_ready = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_e_valid", e_valid, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_meta_valid", meta_valid, 0);
        check("rst_e_addr", e_addr, 0);
        check("rst_meta_tag", meta_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // 1: aligned LD word to even bank
        e_ready = 1'b1; o_ready = 1'b1;
        drive(32'h100, 32'h0, 2'd3, 3'd1, 10'd1);
        step(); req_valid = 1'b0; #1;
        check("t1_e_valid", e_valid, 1);
        check("t1_e_addr", e_addr, 32'h100);
        check("t1_o_valid", o_valid, 0);
        check("t1_meta_valid", meta_valid, 1);
        check("t1_meta_split", meta_split, 0);
        check("t1_meta_tag", meta_tag, 1);
        step();
        check("t1_drained", e_valid, 0);

        // 2: line-crossing LD, both banks in one cycle
        drive(32'h10E, 32'h0, 2'd3, 3'd1, 10'd2);
        step(); req_valid = 1'b0; #1;
        check("t2_e_valid", e_valid, 1);
        check("t2_o_valid", o_valid, 1);
        check("t2_e_addr", e_addr, 32'h10E);
        check("t2_o_addr", o_addr, 32'h110);
        check("t2_meta_split", meta_split, 1);
        check("t2_meta_valid", meta_valid, 1);
        step();
        check("t2_one_pop", e_valid | o_valid, 0);

        // 3: crossing ST, odd accepted first, even stalls -> WAIT_E
        e_ready = 1'b0; o_ready = 1'b1;
        drive(32'h11D, 32'hAABBCCDD, 2'd3, 3'd2, 10'd3);
        step(); req_valid = 1'b0; #1;
        check("t3_o_addr", o_addr, 32'h11D);
        check("t3_o_data", o_data, 32'hAABBCCDD);
        check("t3_e_addr", e_addr, 32'h120);
        check("t3_e_data", e_data, 32'h000000AA);
        check("t3_meta_early", meta_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_wait_e_valid", e_valid, 1);
            check("t3_wait_o_valid", o_valid, 0);
            check("t3_wait_e_data", e_data, 32'h000000AA);
            check("t3_wait_meta", meta_valid, 0);
        end
        e_ready = 1'b1; #1;
        check("t3_meta_valid", meta_valid, 1);
        check("t3_meta_split", meta_split, 1);
        check("t3_meta_tag", meta_tag, 3);
        check("t3_meta_size", meta_size, 3);
        step();
        check("t3_drained", e_valid, 0);

        // 4: fill buffer with banks stalled, then drain in order
        e_ready = 1'b0; o_ready = 1'b0;
        drive(32'h200, 32'h0, 2'd3, 3'd1, 10'd4);
        step();
        drive(32'h210, 32'h0, 2'd3, 3'd1, 10'd5); #1;
        check("t4_ready_1", req_ready, 1);
        step();
        check("t4_full", req_ready, 0);
        drive(32'h220, 32'h0, 2'd3, 3'd1, 10'd6);
        step();
        check("t4_still_full", req_ready, 0);
        check("t4_hold_e_addr", e_addr, 32'h200);
        e_ready = 1'b1; o_ready = 1'b1; #1;
        check("t4_a_tag", meta_tag, 4);
        step();
        check("t4_b_o_addr", o_addr, 32'h210);
        check("t4_b_tag", meta_tag, 5);
        check("t4_b_ready", req_ready, 1);
        step(); req_valid = 1'b0; #1;
        check("t4_c_e_addr", e_addr, 32'h220);
        check("t4_c_tag", meta_tag, 6);
        step();
        check("t4_empty", e_valid | o_valid, 0);

        // NOOP: no bank valid, no meta
        drive(32'h300, 32'h0, 2'd3, 3'd0, 10'd8);
        step(); req_valid = 1'b0; #1;
        check("noop_valid", e_valid | o_valid, 0);
        check("noop_meta", meta_valid, 0);

        // WR crossing a line is never split
        step();
        drive(32'h10E, 32'h0, 2'd3, 3'd4, 10'd10);
        step(); req_valid = 1'b0; #1;
        check("wr_e_valid", e_valid, 1);
        check("wr_o_valid", o_valid, 0);
        check("wr_meta_split", meta_split, 0);
        step();

        // 6: misaligned half
        drive(32'h101, 32'h0, 2'd1, 3'd1, 10'd9);
        step(); req_valid = 1'b0; #1;
`ifdef D_SPLIT_ALIGN_CHECK_EN
        check("t6_mis_valid", misalign_valid, 1);
        check("t6_mis_tag", misalign_tag, 9);
        check("t6_no_bank", e_valid | o_valid, 0);
        check("t6_no_meta", meta_valid, 0);
`else
        check("t6_e_valid", e_valid, 1);
        check("t6_e_addr", e_addr, 32'h101);
        check("t6_meta_split", meta_split, 0);
`endif
        step();

        // 5: wrap of secondary address, reset while in WAIT_O
        e_ready = 1'b1; o_ready = 1'b0;
        drive(32'hFFFFFFFE, 32'h11223344, 2'd3, 3'd1, 10'd7);
        step(); req_valid = 1'b0; #1;
        check("t5_e_addr", e_addr, 32'h0);
        check("t5_o_addr", o_addr, 32'hFFFFFFFE);
        check("t5_e_data", e_data, 32'h00001122);
        step();
        check("t5_wait_o", o_valid, 1);
        check("t5_wait_e_off", e_valid, 0);
        rst = 1'b0; #1;
        check("t5_rst_valid", e_valid | o_valid, 0);
        check("t5_rst_meta", meta_valid, 0);
        check("t5_rst_ready", req_ready, 1);
        o_ready = 1'b1;
        step(); rst = 1'b1;
        step();
        check("t5_after_rst", e_valid | o_valid | meta_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
